ip_vdp_port_arbiter: RTL and testbench



---
 rtl/ip_vdp_pkg.sv | 27 ++
 rtl/ip_vdp_pair_lock.sv | 54 +++++
 rtl/ip_vdp_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_ip_vdp_port_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ip_vdp_pkg.sv
// Shared VDP CPU-port definitions: port numbers, arbiter states, requester ids, command bundle.
// Latency: none (types and constants only); backpressure: n/a.
package ip_vdp_pkg;

   localparam logic [1:0] C_VDP_PORT0 = 2'd0;
   localparam logic [1:0] C_VDP_PORT1 = 2'd1;
   localparam logic [1:0] C_VDP_PORT2 = 2'd2;
   localparam logic [1:0] C_VDP_PORT3 = 2'd3;

   localparam logic C_REQ_CPU = 1'b0;
   localparam logic C_REQ_DBG = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_SREL,
      ST_MREL,
      ST_GAP
   } state_t;

   typedef struct packed {
      logic       wr;
      logic [1:0] address;
      logic [7:0] wdata;
   } vdp_cmd_t;

endpackage

// File: rtl/ip_vdp_pair_lock.sv
// Tracks the port#1 two-byte write pair and holds the bus for its owner until the pair completes.
// Latency: lock updates 1 clk after the done strobe; backpressure: stale lock released after LOCK_TIMEOUT idle clk.
module ip_vdp_pair_lock
   import ip_vdp_pkg::*;
#(
   parameter int LOCK_TIMEOUT = 1023
) (
   input  logic       clk,
   input  logic       n_reset,
   input  logic       done,
   input  logic       done_wr,
   input  logic [1:0] done_address,
   input  logic       done_grant,
   input  logic       idle,
   input  logic [1:0] req,
   output logic       lock_active,
   output logic       lock_owner,
   output logic       lock_timeout
);

   localparam logic [9:0] C_TO_LAST = 10'(LOCK_TIMEOUT - 1);

   logic [9:0] idle_cnt;
   logic       run;
   logic       expire;

   // The pair flag and the lock are the same bit: the lock exists exactly while half a pair is written.
   assign run    = lock_active && idle && !req[lock_owner];
   assign expire = run && (idle_cnt == C_TO_LAST);

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         lock_active  <= 1'b0;
         lock_owner   <= C_REQ_CPU;
         lock_timeout <= 1'b0;
         idle_cnt     <= '0;
      end else begin
         lock_timeout <= expire;
         idle_cnt     <= (run && !expire) ? idle_cnt + 10'd1 : '0;
         if (expire) begin
            lock_active <= 1'b0;
         end else if (done && done_address == C_VDP_PORT1) begin
            if (!done_wr) begin
               lock_active <= 1'b0;
            end else begin
               lock_active <= !lock_active;
               if (!lock_active)
                  lock_owner <= done_grant;
            end
         end
      end
   end

endmodule

// File: rtl/ip_vdp_port_arbiter.sv
// Two-requester arbiter for the VDP CPU port (4-phase req/ack), m0 priority, pair lock, idle gap.
// Latency: s_req 1 clk after grant; backpressure: losers hold req, gap of GAP_CYCLES clk after each access.
module ip_vdp_port_arbiter
   import ip_vdp_pkg::*;
#(
   parameter int GAP_CYCLES   = 2,
   parameter int LOCK_TIMEOUT = 1023
) (
   input  logic       clk,
   input  logic       n_reset,
   input  logic       m0_req,
   output logic       m0_ack,
   input  logic       m0_wr,
   input  logic [1:0] m0_address,
   input  logic [7:0] m0_wdata,
   output logic [7:0] m0_rdata,
   input  logic       m1_req,
   output logic       m1_ack,
   input  logic       m1_wr,
   input  logic [1:0] m1_address,
   input  logic [7:0] m1_wdata,
   output logic [7:0] m1_rdata,
   output logic       s_req,
   input  logic       s_ack,
   output logic       s_wr,
   output logic [1:0] s_address,
   output logic [7:0] s_wdata,
   input  logic [7:0] s_rdata,
   output logic       lock_active,
   output logic       lock_timeout
);

   localparam logic [3:0] C_GAP = 4'(GAP_CYCLES);

   state_t     state, state_nxt;
   vdp_cmd_t   s_cmd;
   logic       grant;
   logic       lock_owner;
   logic [3:0] gap_cnt;
   logic [1:0] req_vec, elig_vec;
   logic       grant_sel, elig_any;
   logic       take, s_hit, ack_set, done;

   assign req_vec   = {m1_req, m0_req};
   assign elig_vec  = lock_active ? (req_vec & (lock_owner ? 2'b10 : 2'b01)) : req_vec;
   assign elig_any  = |elig_vec;
   assign grant_sel = elig_vec[0] ? C_REQ_CPU : C_REQ_DBG;

   assign s_wr      = s_cmd.wr;
   assign s_address = s_cmd.address;
   assign s_wdata   = s_cmd.wdata;

   always_ff @(posedge clk) begin
      if (!n_reset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (elig_any)        state_nxt = ST_REQ;
         ST_REQ:  if (s_ack)           state_nxt = ST_SREL;
         ST_SREL: if (!s_ack)          state_nxt = ST_MREL;
         ST_MREL: if (!req_vec[grant]) state_nxt = (C_GAP != 4'd0) ? ST_GAP : ST_IDLE;
         ST_GAP:  if (gap_cnt <= 4'd1) state_nxt = ST_IDLE;
         default:                      state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      take    = 1'b0;
      s_hit   = 1'b0;
      ack_set = 1'b0;
      done    = 1'b0;
      case (state)
         ST_IDLE: take    = elig_any;
         ST_REQ:  s_hit   = s_ack;
         ST_SREL: ack_set = !s_ack;
         ST_MREL: done    = !req_vec[grant];
         default: ;
      endcase
   end

   // Command is captured at grant; later requester-side changes are deliberately ignored.
   always_ff @(posedge clk) begin
      if (!n_reset) begin
         s_req    <= 1'b0;
         s_cmd    <= '0;
         grant    <= C_REQ_CPU;
         m0_ack   <= 1'b0;
         m1_ack   <= 1'b0;
         m0_rdata <= 8'h00;
         m1_rdata <= 8'h00;
         gap_cnt  <= '0;
      end else begin
         if (take) begin
            grant <= grant_sel;
            s_req <= 1'b1;
            s_cmd <= grant_sel ? vdp_cmd_t'{m1_wr, m1_address, m1_wdata}
                               : vdp_cmd_t'{m0_wr, m0_address, m0_wdata};
         end
         if (s_hit) begin
            s_req <= 1'b0;
            if (!s_cmd.wr) begin
               if (grant) m1_rdata <= s_rdata;
               else       m0_rdata <= s_rdata;
            end
         end
         if (ack_set) begin
            m0_ack <= !grant;
            m1_ack <= grant;
         end
         if (done) begin
            m0_ack  <= 1'b0;
            m1_ack  <= 1'b0;
            gap_cnt <= C_GAP;
         end else if (state == ST_GAP && gap_cnt != 4'd0) begin
            gap_cnt <= gap_cnt - 4'd1;
         end
      end
   end

   ip_vdp_pair_lock #(
      .LOCK_TIMEOUT (LOCK_TIMEOUT)
   ) u_pair_lock (
      .clk          (clk),
      .n_reset      (n_reset),
      .done         (done),
      .done_wr      (s_cmd.wr),
      .done_address (s_cmd.address),
      .done_grant   (grant),
      .idle         (state == ST_IDLE),
      .req          (req_vec),
      .lock_active  (lock_active),
      .lock_owner   (lock_owner),
      .lock_timeout (lock_timeout)
   );

endmodule

// File: tb/tb_ip_vdp_port_arbiter.sv
// Directed scoreboard bench for ip_vdp_port_arbiter: target-side and ack-side monitors pop expectations.
module tb_ip_vdp_port_arbiter;

   localparam int GAP = 2;
   localparam int TO  = 16;
   localparam int LAT = 3;

   typedef struct {
      int         who;
      bit         wr;
      logic [1:0] addr;
      logic [7:0] wd;
      bit         lk;
   } sexp_t;

   logic       clk = 1'b0;
   logic       n_reset;
   logic       m_req [2];
   logic       m_wr [2];
   logic [1:0] m_addr [2];
   logic [7:0] m_wdata [2];
   logic       m0_ack, m1_ack;
   logic [7:0] m0_rdata, m1_rdata;
   logic       s_req, s_ack, s_wr;
   logic [1:0] s_address;
   logic [7:0] s_wdata, s_rdata;
   logic       lock_active, lock_timeout;

   int         n_cmp = 0;
   int         n_fail = 0;
   int         cyc = 0;
   int         last_fall = -1;
   int         cur_who = -1;
   bit         gap_exact = 0;
   logic [7:0] tgt_rdata = 8'hEE;
   logic [7:0] last_rd [2];
   sexp_t      exp_s[$];
   logic [7:0] exp_ack0[$];
   logic [7:0] exp_ack1[$];

   ip_vdp_port_arbiter #(
      .GAP_CYCLES   (GAP),
      .LOCK_TIMEOUT (TO)
   ) dut (
      .clk          (clk),
      .n_reset      (n_reset),
      .m0_req       (m_req[0]),
      .m0_ack       (m0_ack),
      .m0_wr        (m_wr[0]),
      .m0_address   (m_addr[0]),
      .m0_wdata     (m_wdata[0]),
      .m0_rdata     (m0_rdata),
      .m1_req       (m_req[1]),
      .m1_ack       (m1_ack),
      .m1_wr        (m_wr[1]),
      .m1_address   (m_addr[1]),
      .m1_wdata     (m_wdata[1]),
      .m1_rdata     (m1_rdata),
      .s_req        (s_req),
      .s_ack        (s_ack),
      .s_wr         (s_wr),
      .s_address    (s_address),
      .s_wdata      (s_wdata),
      .s_rdata      (s_rdata),
      .lock_active  (lock_active),
      .lock_timeout (lock_timeout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic ack_of(input int idx);
      return (idx == 1) ? m1_ack : m0_ack;
   endfunction

   task automatic push_s(input int who, input bit wr, input logic [1:0] addr,
                         input logic [7:0] wd, input bit lk);
      sexp_t e;
      e.who = who; e.wr = wr; e.addr = addr; e.wd = wd; e.lk = lk;
      exp_s.push_back(e);
   endtask

   // One full 4-phase access from requester idx; returns at the negedge where ack is seen low.
   task automatic access(input int idx, input bit wr, input logic [1:0] addr,
                         input logic [7:0] wd, input logic [7:0] rd);
      int k;
      if (!wr) begin
         tgt_rdata   = rd;
         last_rd[idx] = rd;
      end
      if (idx == 0) exp_ack0.push_back(last_rd[0]);
      else          exp_ack1.push_back(last_rd[1]);
      m_wr[idx] = wr; m_addr[idx] = addr; m_wdata[idx] = wd; m_req[idx] = 1'b1;
      k = 0;
      while (ack_of(idx) !== 1'b1 && k < 300) begin @(negedge clk); k++; end
      chk($sformatf("m%0d_ack_rise_in_time", idx), 32'(k < 300), 32'd1);
      m_req[idx] = 1'b0;
      k = 0;
      while (ack_of(idx) !== 1'b0 && k < 300) begin @(negedge clk); k++; end
      chk($sformatf("m%0d_ack_fall_in_time", idx), 32'(k < 300), 32'd1);
   endtask

   // Target model: acks LAT negedges after s_req is seen, releases when s_req drops.
   int tcnt = 0;
   always @(negedge clk) begin
      if (s_req !== 1'b1) begin
         s_ack = 1'b0;
         tcnt  = 0;
      end else if (!s_ack) begin
         tcnt++;
         if (tcnt >= LAT) begin
            s_ack   = 1'b1;
            s_rdata = tgt_rdata;
         end
      end
   end

   // Scoreboard monitor.
   logic prev_sreq = 1'b0, prev_ack0 = 1'b0, prev_ack1 = 1'b0;
   always @(negedge clk) begin
      sexp_t e;
      if (s_req === 1'b1 && !prev_sreq) begin
         if (exp_s.size() == 0) begin
            chk("s_req_unexpected", 32'd1, 32'd0);
         end else begin
            e = exp_s.pop_front();
            cur_who = e.who;
            chk("s_wr", 32'(s_wr), 32'(e.wr));
            chk("s_address", 32'(s_address), 32'(e.addr));
            chk("s_wdata", 32'(s_wdata), 32'(e.wd));
            chk("lock_at_grant", 32'(lock_active), 32'(e.lk));
            if (gap_exact && last_fall >= 0)
               chk("gap_spacing", 32'(cyc - last_fall), 32'(GAP + 1));
         end
      end
      if (m0_ack === 1'b1 && !prev_ack0) begin
         chk("m0_ack_owner", 32'(cur_who), 32'd0);
         if (exp_ack0.size() == 0) chk("m0_ack_unexpected", 32'd1, 32'd0);
         else chk("m0_rdata", 32'(m0_rdata), 32'(exp_ack0.pop_front()));
      end
      if (m1_ack === 1'b1 && !prev_ack1) begin
         chk("m1_ack_owner", 32'(cur_who), 32'd1);
         if (exp_ack1.size() == 0) chk("m1_ack_unexpected", 32'd1, 32'd0);
         else chk("m1_rdata", 32'(m1_rdata), 32'(exp_ack1.pop_front()));
      end
      if ((prev_ack0 && m0_ack !== 1'b1) || (prev_ack1 && m1_ack !== 1'b1))
         last_fall = cyc;
      prev_sreq = (s_req === 1'b1);
      prev_ack0 = (m0_ack === 1'b1);
      prev_ack1 = (m1_ack === 1'b1);
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int k;
      n_reset = 1'b0;
      s_ack = 1'b0; s_rdata = 8'h00;
      for (int i = 0; i < 2; i++) begin
         m_req[i] = 1'b0; m_wr[i] = 1'b0; m_addr[i] = 2'd0; m_wdata[i] = 8'h00; last_rd[i] = 8'h00;
      end
      repeat (3) @(negedge clk);
      chk("rst_s_req", 32'(s_req), 32'd0);
      chk("rst_acks", 32'({m0_ack, m1_ack}), 32'd0);
      chk("rst_s_cmd", 32'({s_wr, s_address, s_wdata}), 32'd0);
      chk("rst_rdata", 32'({m0_rdata, m1_rdata}), 32'd0);
      chk("rst_lock", 32'({lock_active, lock_timeout}), 32'd0);
      n_reset = 1'b1;
      repeat (2) @(negedge clk);

      // m1 register-write pair on port1
      push_s(1, 1, 2'd1, 8'h50, 0);
      push_s(1, 1, 2'd1, 8'h81, 1);
      access(1, 1, 2'd1, 8'h50, 8'h00);
      chk("t1_lock_mid_pair", 32'(lock_active), 32'd1);
      gap_exact = 1;
      access(1, 1, 2'd1, 8'h81, 8'h00);
      gap_exact = 0;
      chk("t1_lock_after_pair", 32'(lock_active), 32'd0);
      repeat (4) @(negedge clk);

      // same-edge contention, m0 priority
      push_s(0, 1, 2'd0, 8'hAA, 0);
      push_s(1, 1, 2'd0, 8'h55, 0);
      fork
         access(0, 1, 2'd0, 8'hAA, 8'h00);
         access(1, 1, 2'd0, 8'h55, 8'h00);
      join
      repeat (4) @(negedge clk);

      // m0 must not split m1's pair
      push_s(1, 1, 2'd1, 8'h00, 0);
      push_s(1, 1, 2'd1, 8'h87, 1);
      push_s(0, 1, 2'd0, 8'h12, 0);
      access(1, 1, 2'd1, 8'h00, 8'h00);
      fork
         access(1, 1, 2'd1, 8'h87, 8'h00);
         access(0, 1, 2'd0, 8'h12, 8'h00);
      join
      repeat (4) @(negedge clk);

      // port1 read clears m0's half-written pair; rdata capture and hold
      push_s(0, 1, 2'd1, 8'h3C, 0);
      push_s(0, 0, 2'd1, 8'h3C, 1);
      push_s(1, 0, 2'd0, 8'h00, 0);
      push_s(0, 1, 2'd0, 8'h7E, 0);
      access(0, 1, 2'd1, 8'h3C, 8'h00);
      m_wdata[0] = 8'h3C;
      access(0, 0, 2'd1, 8'h3C, 8'h9F);
      chk("t4_lock_cleared_by_read", 32'(lock_active), 32'd0);
      chk("t4_m0_rdata_held", 32'(m0_rdata), 32'h9F);
      m_wdata[1] = 8'h00;
      access(1, 0, 2'd0, 8'h00, 8'hC4);
      tgt_rdata = 8'hEE;
      access(0, 1, 2'd0, 8'h7E, 8'h00);
      chk("t4_m1_rdata_held", 32'(m1_rdata), 32'hC4);
      repeat (4) @(negedge clk);

      // stale lock released by timeout, then pending m0 served
      push_s(1, 1, 2'd1, 8'h01, 0);
      push_s(0, 1, 2'd3, 8'h5A, 0);
      access(1, 1, 2'd1, 8'h01, 8'h00);
      fork
         access(0, 1, 2'd3, 8'h5A, 8'h00);
         begin
            k = 0;
            do begin @(negedge clk); k++; end while (lock_timeout !== 1'b1 && k < 100);
            chk("t5_timeout_delay", 32'(k), 32'(GAP + TO));
            chk("t5_lock_released", 32'(lock_active), 32'd0);
            @(negedge clk);
            chk("t5_timeout_one_clk", 32'(lock_timeout), 32'd0);
         end
      join
      repeat (4) @(negedge clk);

      // reset during ST_REQ aborts the access
      push_s(1, 1, 2'd2, 8'h44, 0);
      m_wr[1] = 1'b1; m_addr[1] = 2'd2; m_wdata[1] = 8'h44; m_req[1] = 1'b1;
      k = 0;
      while (s_req !== 1'b1 && k < 50) begin @(negedge clk); k++; end
      chk("t6_s_req_seen", 32'(k < 50), 32'd1);
      n_reset = 1'b0;
      m_req[1] = 1'b0;
      @(negedge clk);
      chk("t6_s_req_dropped", 32'(s_req), 32'd0);
      chk("t6_acks", 32'({m0_ack, m1_ack}), 32'd0);
      chk("t6_rdata", 32'({m0_rdata, m1_rdata}), 32'd0);
      chk("t6_s_cmd", 32'({s_wr, s_address, s_wdata}), 32'd0);
      @(negedge clk);
      n_reset = 1'b1;
      last_rd[0] = 8'h00; last_rd[1] = 8'h00;
      repeat (2) @(negedge clk);
      push_s(1, 1, 2'd2, 8'h33, 0);
      access(1, 1, 2'd2, 8'h33, 8'h00);
      repeat (4) @(negedge clk);

      chk("left_s_expect", 32'(exp_s.size()), 32'd0);
      chk("left_ack0_expect", 32'(exp_ack0.size()), 32'd0);
      chk("left_ack1_expect", 32'(exp_ack1.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
